// File: rtl/imem_boot_loader.sv
// Byte-serial loader for the RV32I instruction SRAM: parses a length-prefixed,
// checksummed frame, writes little-endian words and releases core reset once verified.
module imem_boot_loader #(
  parameter int WORDS  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_HDR_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;

  logic              xfer_s;
  logic [15:0]       len_new_s;
  logic [15:0]       last_idx_s;

  // Output decode from the registered state
  always_comb begin
    rx_ready   = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                 (state_q == S_DATA)   || (state_q == S_CSUM);
    mem_csb    = (state_q != S_WRITE);
    mem_web    = (state_q != S_WRITE);
    mem_addr   = addr_q;
    mem_din    = din_q;
    core_reset = (state_q != S_DONE);
    done       = (state_q == S_DONE);
    error      = (state_q == S_ERROR);
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    widx_d     = widx_q;
    addr_d     = addr_q;
    din_d      = din_q;
    xfer_s     = rx_valid && rx_ready;
    len_new_s  = {rx_data, len_q[7:0]};
    last_idx_s = len_q - 16'd1;

    case (state_q)
      S_IDLE: begin
        state_d = S_HDR_LO;
        csum_d  = 8'd0;
      end
      S_HDR_LO: begin
        if (xfer_s) begin
          len_d[7:0] = rx_data;
          csum_d     = csum_q + rx_data;
          state_d    = S_HDR_LO + 3'd1;
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_HDR_HI: begin
        if (xfer_s) begin
          len_d[15:8] = rx_data;
          csum_d      = csum_q + rx_data;
          // Zero-length and oversize images are rejected before any SRAM write
          if ((len_new_s == 16'd0) || (len_new_s > 16'(WORDS))) begin
            state_d = S_ERROR;
          end else begin
            widx_d     = '0;
            byte_cnt_d = 2'd0;
            state_d    = S_DATA;
          end
        end else begin
          state_d = S_HDR_HI;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          csum_d     = csum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: begin
              addr_d  = widx_q;
              din_d   = {rx_data, word_q};
              state_d = S_WRITE;
            end
          endcase
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        widx_d = widx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (16'(widx_q) == last_idx_s) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer_s) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_d = S_HDR_LO;
          csum_d  = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      csum_q     <= 8'd0;
      word_q     <= 24'd0;
      byte_cnt_q <= 2'd0;
      widx_q     <= '0;
      addr_q     <= '0;
      din_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      widx_q     <= widx_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: frames built from a byte-level model,
// expected SRAM writes queued at issue time and popped by an independent monitor.
module tb_imem_boot_loader;

  localparam int WORDS  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic              mem_csb;
  logic              mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              core_reset;
  logic              done;
  logic              error;

  imem_boot_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .mem_csb(mem_csb), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_din(mem_din), .core_reset(core_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  logic [31:0] img [0:WORDS-1];
  int n_tests = 0;
  int n_fail  = 0;
  logic prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every SRAM write cycle must match the head of the scoreboard
  always @(negedge clk) begin
    logic wr_now;
    wr_t  e;
    if (!reset) begin
      prev_wr = 1'b0;
    end else begin
      wr_now = (mem_csb === 1'b0) && (mem_web === 1'b0);
      if (wr_now) begin
        check("write_rx_ready_low", {31'd0, rx_ready}, 32'd0);
        check("write_single_cycle", {31'd0, prev_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_din);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e.addr));
          check("write_data", mem_din, e.data);
        end
      end
      prev_wr = wr_now;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd0);
    check({tag, "_mem_csb"},    {31'd0, mem_csb},    32'd1);
    check({tag, "_mem_web"},    {31'd0, mem_web},    32'd1);
    check({tag, "_mem_addr"},   32'(mem_addr),       32'd0);
    check({tag, "_mem_din"},    mem_din,             32'd0);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_error"},      {31'd0, error},      32'd0);
  endtask

  // Called just after a negedge; returns just after the negedge following the transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   cyc;
    logic acc;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 1000) begin
      acc = rx_ready;
      @(negedge clk);
      cyc++;
    end
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_timeout: byte 0x%0h not accepted in %0d cycles, expected acceptance", b, cyc);
    end
  endtask

  // Reference model: frame = LEN(16b LE), N words LE, sum of all prior bytes mod 256
  task automatic build_frame(input int len, input int csum_delta, output bit exp_done);
    int sum;
    wr_t w;
    frame_q = {};
    frame_q.push_back(8'(len % 256));
    frame_q.push_back(8'(len / 256));
    sum = (len % 256) + (len / 256);
    exp_done = 1'b0;
    if (len >= 1 && len <= WORDS) begin
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 4; k++) begin
          frame_q.push_back(8'((img[i] >> (8 * k)) & 32'hFF));
          sum += (img[i] >> (8 * k)) & 32'hFF;
        end
        w.addr = ADDR_W'(i);
        w.data = img[i];
        exp_q.push_back(w);
      end
      frame_q.push_back(8'((sum + csum_delta) % 256));
      exp_done = (csum_delta % 256) == 0;
    end
  endtask

  task automatic run_frame(input string tag, input int len, input int csum_delta, input int max_gap);
    bit exp_done;
    build_frame(len, csum_delta, exp_done);
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], $urandom_range(0, max_gap));
    check({tag, "_done"},       {31'd0, done},       {31'd0, exp_done});
    check({tag, "_error"},      {31'd0, error},      {31'd0, !exp_done});
    check({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !exp_done});
    check({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()),  32'd0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_error"},      {31'd0, error},      32'd0);
    check({tag, "_rx_ready"},   {31'd0, rx_ready},   32'd1);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    reload   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

    img[0] = 32'h0000_0013;
    run_frame("single", 1, 0, 0);
    do_reload("reload1");

    img[0] = 32'h0050_0093; img[1] = 32'h00A0_0113; img[2] = 32'h0020_81B3;
    run_frame("three", 3, 0, 4);
    do_reload("reload2");
    run_frame("three_badsum", 3, 1, 4);
    do_reload("reload3");

    run_frame("len0", 0, 0, 2);
    do_reload("reload4");
    run_frame("len257", 257, 0, 2);
    do_reload("reload5");

    // Reset in the middle of the first word, then reload the single-word image
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h00, 0);
    #2 reset = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    img[0] = 32'h0000_0013;
    run_frame("after_reset", 1, 0, 1);

    do_reload("done_reload");
    img[0] = 32'hDEAD_BEEF; img[1] = 32'h1234_5678;
    run_frame("two", 2, 0, 2);
    do_reload("reload6");

    for (int i = 0; i < WORDS; i++) img[i] = $urandom;
    run_frame("max_len", WORDS, 0, 0);
    do_reload("reload7");

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(WORDS + 1, 1000);
      for (int i = 0; i < 8; i++) img[i] = $urandom;
      run_frame("rand", n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0, 3);
      do_reload("rand_reload");
    end

    repeat (3) @(negedge clk);
    check("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
